// File: rtl/wb_resp_pkg.sv
// Shared types and defaults for the Wishbone data-bus responder.
// Holds the FSM state enum, default widths and the wait-state ceiling.
package wb_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } resp_state_t;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 8;
  localparam int WAIT_MAX  = 15;

endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous RAM, read-first, registered read data.
// Ports: clk, we (write enable), addr, wdata, rdata (registered).
module ram_sp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/wb_data_responder.sv
// Wishbone-classic data-bus responder: word RAM with programmable wait
// states before a single-cycle ack.
// Ports: clk, rst (sync, active-high); cyc_i/stb_i/we_i/adr_i/dat_i
// request side; dat_o/ack_o completion side; busy_o while in WAIT/ACK.
module wb_data_responder
  import wb_resp_pkg::*;
#(
  parameter int DATA_W   = WB_DATA_W,
  parameter int ADDR_W   = WB_ADDR_W,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] adr_i,
  input  logic [DATA_W-1:0] dat_i,
  output logic [DATA_W-1:0] dat_o,
  output logic              ack_o,
  output logic              busy_o
);

  // Out-of-range settings are clamped to the legal 0..WAIT_MAX window.
  localparam int WC =
    (WAIT_CYC > WAIT_MAX) ? WAIT_MAX :
    (WAIT_CYC < 0)        ? 0        : WAIT_CYC;

  localparam logic [3:0] WLOAD =
    (WC > 0) ? 4'(WC - 1) : 4'd0;

  resp_state_t       state;
  resp_state_t       state_n;
  logic [3:0]        wcnt;
  logic [3:0]        wcnt_n;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] dat_q;
  logic              we_q;

  logic              req;
  logic              accept;
  logic              enter_ack;
  logic              live;
  logic [ADDR_W-1:0] ram_adr;
  logic [DATA_W-1:0] ram_wd;
  logic              ram_wflag;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rd;

  assign req    = cyc_i & stb_i;
  assign accept = (state == IDLE) & req;

  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (WC == 0) begin
            state_n = ACK;
          end else begin
            state_n = WAIT;
            wcnt_n  = WLOAD;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_n = IDLE;
          wcnt_n  = 4'd0;
        end else if (wcnt == 4'd0) begin
          state_n = ACK;
        end else begin
          wcnt_n = wcnt - 4'd1;
        end
      end
      ACK: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        wcnt_n  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wcnt  <= 4'd0;
      adr_q <= '0;
      dat_q <= '0;
      we_q  <= 1'b0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
      if (accept) begin
        adr_q <= adr_i;
        dat_q <= dat_i;
        we_q  <= we_i;
      end
    end
  end

  // With zero wait states the RAM access happens on the accepting edge,
  // so the values being latched on that edge are routed straight through.
  assign enter_ack = (state_n == ACK) & (state != ACK);
  assign live      = (state == IDLE);
  assign ram_adr   = live ? adr_i : adr_q;
  assign ram_wd    = live ? dat_i : dat_q;
  assign ram_wflag = live ? we_i  : we_q;
  assign ram_we    = ~rst & enter_ack & ram_wflag;

  ram_sp #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_adr),
    .wdata(ram_wd),
    .rdata(ram_rd)
  );

  assign ack_o  = (state == ACK);
  assign busy_o = (state != IDLE);
  assign dat_o  = (ack_o & ~we_q) ? ram_rd : '0;

endmodule

// File: tb/tb_wb_data_responder.sv
// Scoreboard bench for wb_data_responder at WAIT_CYC 0..3.
// Instance i runs with WAIT_CYC=i; a monitor checks every ack.
module tb_wb_data_responder;

  typedef struct {
    int          cyc;
    logic        rd;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst  [4];
  logic        cyc  [4];
  logic        stb  [4];
  logic        we   [4];
  logic [7:0]  adr  [4];
  logic [31:0] din  [4];
  logic [31:0] dout [4];
  logic        ack  [4];
  logic        busy [4];
  logic        pack [4];

  exp_t sbq [4][$];
  exp_t me;
  int   cnt    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   nst;

  always #5 clk = ~clk;

  always @(posedge clk) cnt <= cnt + 1;

  wb_data_responder #(.DATA_W(32), .ADDR_W(8), .WAIT_CYC(0)) u0 (
    .clk(clk), .rst(rst[0]), .cyc_i(cyc[0]), .stb_i(stb[0]),
    .we_i(we[0]), .adr_i(adr[0]), .dat_i(din[0]),
    .dat_o(dout[0]), .ack_o(ack[0]), .busy_o(busy[0])
  );
  wb_data_responder #(.DATA_W(32), .ADDR_W(8), .WAIT_CYC(1)) u1 (
    .clk(clk), .rst(rst[1]), .cyc_i(cyc[1]), .stb_i(stb[1]),
    .we_i(we[1]), .adr_i(adr[1]), .dat_i(din[1]),
    .dat_o(dout[1]), .ack_o(ack[1]), .busy_o(busy[1])
  );
  wb_data_responder #(.DATA_W(32), .ADDR_W(8), .WAIT_CYC(2)) u2 (
    .clk(clk), .rst(rst[2]), .cyc_i(cyc[2]), .stb_i(stb[2]),
    .we_i(we[2]), .adr_i(adr[2]), .dat_i(din[2]),
    .dat_o(dout[2]), .ack_o(ack[2]), .busy_o(busy[2])
  );
  wb_data_responder #(.DATA_W(32), .ADDR_W(8), .WAIT_CYC(3)) u3 (
    .clk(clk), .rst(rst[3]), .cyc_i(cyc[3]), .stb_i(stb[3]),
    .we_i(we[3]), .adr_i(adr[3]), .dat_i(din[3]),
    .dat_o(dout[3]), .ack_o(ack[3]), .busy_o(busy[3])
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cnt);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ack[i] === 1'b1) begin
        if (sbq[i].size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_ack inst %0d: got ack=1 required 0 (cycle %0d)",
                   i, cnt);
        end else begin
          me = sbq[i].pop_front();
          chk($sformatf("ack_cycle_i%0d", i), cnt, me.cyc);
          if (me.rd) chk($sformatf("rd_data_i%0d", i), dout[i], me.data);
        end
      end else if (pack[i] === 1'b1) begin
        chk($sformatf("dat_clear_i%0d", i), dout[i], 32'h0);
      end
      pack[i] = ack[i];
    end
  end

  task automatic drive(input int i, input logic c, input logic s,
                       input logic w, input logic [7:0] a,
                       input logic [31:0] d);
    cyc[i] = c;
    stb[i] = s;
    we[i]  = w;
    adr[i] = a;
    din[i] = d;
  endtask

  task automatic push(input int i, input int c, input logic rd,
                      input logic [31:0] d);
    exp_t e;
    e.cyc  = c;
    e.rd   = rd;
    e.data = d;
    sbq[i].push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transfer on instance i (WAIT_CYC=i), started at a cycle start.
  task automatic xfer(input int i, input logic w, input logic [7:0] a,
                      input logic [31:0] d, input logic [31:0] ed);
    drive(i, 1'b1, 1'b1, w, a, d);
    push(i, cnt + 1 + i, ~w, ed);
    for (int k = 0; k <= i + 1; k++) begin
      @(negedge clk);
      chk($sformatf("busy_i%0d_k%0d", i, k), {31'h0, busy[i]},
          (k >= 1) ? 32'h1 : 32'h0);
      tick();
    end
    drive(i, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    chk($sformatf("busy_end_i%0d", i), {31'h0, busy[i]}, 32'h0);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst[i]  = 1'b1;
      pack[i] = 1'b0;
      drive(i, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    end
    tick();
    tick();
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;

    // idle after reset
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        chk("rst_ack", {31'h0, ack[i]}, 32'h0);
        chk("rst_busy", {31'h0, busy[i]}, 32'h0);
        chk("rst_dat", dout[i], 32'h0);
      end
      tick();
    end

    // one wait state: write then read back
    xfer(1, 1'b1, 8'h10, 32'hDEADBEEF, 32'h0);
    xfer(1, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF);

    // zero wait states: held strobe gives acks at N+1 and N+3
    xfer(0, 1'b1, 8'h40, 32'h11112222, 32'h0);
    drive(0, 1'b1, 1'b1, 1'b0, 8'h40, 32'h0);
    push(0, cnt + 1, 1'b1, 32'h11112222);
    push(0, cnt + 3, 1'b1, 32'h11112222);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("held_busy_k%0d", k), {31'h0, busy[0]},
          (k % 2 == 1) ? 32'h1 : 32'h0);
      tick();
    end
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    chk("held_busy_end", {31'h0, busy[0]}, 32'h0);
    tick();

    // three wait states: strobe dropped after first wait cycle
    xfer(3, 1'b1, 8'h20, 32'h0, 32'h0);
    drive(3, 1'b1, 1'b1, 1'b1, 8'h20, 32'h12345678);
    tick();
    @(negedge clk);
    chk("abort_busy_w1", {31'h0, busy[3]}, 32'h1);
    tick();
    drive(3, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    chk("abort_busy_w2", {31'h0, busy[3]}, 32'h1);
    tick();
    @(negedge clk);
    chk("abort_busy_idle", {31'h0, busy[3]}, 32'h0);
    repeat (4) tick();
    xfer(3, 1'b0, 8'h20, 32'h0, 32'h0);

    // two wait states: reset during first wait cycle of a write
    xfer(2, 1'b1, 8'h30, 32'hCAFE0030, 32'h0);
    drive(2, 1'b1, 1'b1, 1'b1, 8'h30, 32'h00000BAD);
    tick();
    rst[2] = 1'b1;
    tick();
    rst[2] = 1'b0;
    drive(2, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    chk("rst_abort_busy", {31'h0, busy[2]}, 32'h0);
    repeat (4) tick();
    xfer(2, 1'b0, 8'h30, 32'h0, 32'hCAFE0030);

    // zero wait states: address extremes
    xfer(0, 1'b1, 8'hFF, 32'h000000A5, 32'h0);
    xfer(0, 1'b1, 8'h00, 32'h0000005A, 32'h0);
    xfer(0, 1'b0, 8'hFF, 32'h0, 32'h000000A5);
    xfer(0, 1'b0, 8'h00, 32'h0, 32'h0000005A);

    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      nst = sbq[i].size();
      chk($sformatf("sb_empty_i%0d", i), nst, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_data_responder.md
# wb_data_responder

Wishbone-classic responder for the processor's data bus: answers `data_cyc`/`data_stb`/`data_we` requests from the control unit with a single-cycle `ack` after a programmable number of wait states. It holds a word-addressed data RAM and sits between the datapath's memory stage and the rest of the design. Its timing lets the control unit see immediate acks (execute→writeback) and stalled acks (MEM_STATE loop).

## Interface
Parameters:
- `DATA_W`, 32: data word width.
- `ADDR_W`, 8: word-address width; RAM depth = 2**ADDR_W.
- `WAIT_CYC`, 1: wait states inserted before `ack_o`. Legal range is 0..15.

Ports:
- `clk` in 1: clock. All state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `cyc_i` in 1: bus cycle valid.
- `stb_i` in 1: strobe, request valid.
- `we_i` in 1: 1 = write, 0 = read.
- `adr_i` in ADDR_W: word address.
- `dat_i` in DATA_W: write data.
- `dat_o` out DATA_W: read data. Valid only while `ack_o`=1.
- `ack_o` out 1: transfer complete. Single-cycle pulse.
- `busy_o` out 1: a request is in progress (WAIT or ACK state).

## Operation
- A request is `cyc_i & stb_i` sampled in IDLE. It is accepted on that edge; `adr_i`, `dat_i` and `we_i` are latched into `adr_q`, `dat_q` and `we_q`.
- FSM states: IDLE, WAIT, ACK.
  - IDLE→ACK when a request is seen and WAIT_CYC=0.
  - IDLE→WAIT when a request is seen and WAIT_CYC>0. `wcnt` is loaded with WAIT_CYC-1.
  - WAIT: `wcnt` decrements each cycle. At `wcnt`==0 the FSM goes to ACK.
  - WAIT abort: if `cyc_i` or `stb_i` is 0 in any WAIT cycle, the FSM goes to IDLE. There is no ack and no RAM write.
  - ACK→IDLE always. `ack_o`=1 for exactly this one cycle.
- Write: RAM[`adr_q`] <= `dat_q` on the edge that enters ACK. Write data comes from the latched values, never from live inputs.
- Read: on the edge that enters ACK, RAM[`adr_q`] is registered into `dat_o`. `dat_o` returns to 0 on the edge leaving ACK.
- `ack_o` is never asserted unless a request was accepted.
- `ack_o` is not gated by the inputs during ACK. The master must hold `stb_i` through ack; if it drops `stb_i`, the transfer is still complete.
- Back-to-back requests: if `cyc_i & stb_i` is still high in the IDLE cycle after ACK, it is a new request. The minimum request-to-request spacing is WAIT_CYC+2 cycles.
- Address space is fully populated, so no error response exists.

## Timing
- Reset values: state IDLE, `ack_o`=0, `dat_o`=0, `busy_o`=0, `wcnt`=0, latched registers 0.
- Reset has priority over every transition. Reset in WAIT or ACK aborts the transfer: no ack, and no write on the reset edge.
- RAM contents are not cleared by reset.
- Latency: request seen in IDLE at cycle N gives `ack_o` high in cycle N+1+WAIT_CYC.
- `busy_o` is high from cycle N+1 through the ACK cycle inclusive.
- Read-after-write to the same address with back-to-back requests returns the new data. The write edge precedes the next read's ACK edge.
- `wcnt` is 4 bits wide and cannot underflow: it is only decremented in WAIT while non-zero.

## Structure
- Package `wb_resp_pkg` holds:
  - the `resp_state_t` enum (IDLE, WAIT, ACK);
  - default width constants `WB_DATA_W`=32 and `WB_ADDR_W`=8;
  - `WAIT_MAX`=15.
- Sub-module `ram_sp`: single-port synchronous RAM with parameters DATA_W and ADDR_W, and ports clk, we, addr, wdata, rdata (registered read). It is instantiated once. The FSM, wait counter and latches live in the top.

## Test plan
- Reset, then idle 5 cycles: `ack_o`=0, `dat_o`=0 and `busy_o`=0 throughout.
- WAIT_CYC=1: write 0xDEADBEEF to 0x10 at cycle 2 → `ack_o` in cycle 4. Then read 0x10 → `ack_o` 2 cycles after the request, with `dat_o`=0xDEADBEEF in the ack cycle only.
- WAIT_CYC=0: read request at cycle N → `ack_o` at N+1. Holding `stb_i` high gives a second ack at N+3 and no ack at N+2.
- WAIT_CYC=3: write 0x12345678 to 0x20, drop `stb_i` after 1 wait cycle → no ack, `busy_o` falls. A later read of 0x20 returns the prior contents (previously written 0x0).
- WAIT_CYC=2: assert `rst` in the first wait cycle of a write to 0x30 → no ack, FSM in IDLE. A read of 0x30 returns the old value.
- WAIT_CYC=0, address wrap: write 0xA5 to 0xFF and 0x5A to 0x00 → reads return 0xA5 and 0x5A respectively, with no aliasing.
